// File: rtl/servo_motion_sequencer.sv
// Slew-limited pulse-width scheduler for a four-servo arm, with pose
// recording and in-order playback (dwell between poses, optional looping).
module servo_motion_sequencer #(
  parameter int CLK_FREQ_HZ  = 25_000_000,
  parameter int FRAME_US     = 20000,
  parameter int STEP_US      = 20,
  parameter int MIN_US       = 650,
  parameter int MAX_US       = 2600,
  parameter int CENTER_US    = 1500,
  parameter int NUM_POSES    = 8,
  parameter int DWELL_FRAMES = 25
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        target_valid,
  output logic        target_ready,
  input  logic [1:0]  target_sel,
  input  logic [11:0] target_us,
  input  logic        store,
  input  logic        clear,
  input  logic        play,
  input  logic        loop_en,
  input  logic        stop,
  input  logic        home,
  output logic [11:0] cmd0,
  output logic [11:0] cmd1,
  output logic [11:0] cmd2,
  output logic [11:0] cmd3,
  output logic [2:0]  state,
  output logic        busy,
  output logic        settled,
  output logic [2:0]  pose_idx,
  output logic [3:0]  pose_count,
  output logic        mem_full,
  output logic        frame_tick
);

  localparam int FRAME_CYCLES = CLK_FREQ_HZ / 1_000_000 * FRAME_US;
  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DWC = $clog2(DWELL_FRAMES + 2);
  localparam int PIW = $clog2(NUM_POSES);

  typedef enum logic [2:0] {
    S_LIVE   = 3'd0,
    S_HOMING = 3'd1,
    S_LOAD   = 3'd2,
    S_MOVE   = 3'd3,
    S_DWELL  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [DWC-1:0]  dwell_q, dwell_d;
  logic [11:0]     tgt_q [4];
  logic [11:0]     tgt_d [4];
  logic [11:0]     cmd_q [4];
  logic [11:0]     cmd_d [4];
  logic [3:0]      pose_count_q, pose_count_d;
  logic [2:0]      pose_idx_q, pose_idx_d;
  logic [47:0]     pose_mem [NUM_POSES];
  logic [47:0]     pose_rd_s;
  logic            frame_tick_s, settled_s, full_s, dwell_done_s, mem_we_s;

  function automatic logic [11:0] clamp_us(input logic [11:0] v);
    logic [11:0] r;
    if (v < 12'(MIN_US)) r = 12'(MIN_US);
    else if (v > 12'(MAX_US)) r = 12'(MAX_US);
    else r = v;
    return r;
  endfunction

  // Differences are taken in 13 bits so a large gap can never wrap.
  function automatic logic [11:0] slew_step(input logic [11:0] c, input logic [11:0] t);
    logic [11:0] r;
    if (c < t) r = (({1'b0, t} - {1'b0, c}) > 13'(STEP_US)) ? c + 12'(STEP_US) : t;
    else if (c > t) r = (({1'b0, c} - {1'b0, t}) > 13'(STEP_US)) ? c - 12'(STEP_US) : t;
    else r = c;
    return r;
  endfunction

  assign frame_tick_s = (fcnt_q == FCW'(FRAME_CYCLES - 1));
  assign settled_s    = (cmd_q[0] == tgt_q[0]) && (cmd_q[1] == tgt_q[1]) &&
                        (cmd_q[2] == tgt_q[2]) && (cmd_q[3] == tgt_q[3]);
  assign full_s       = (pose_count_q == 4'(NUM_POSES));
  assign pose_rd_s    = pose_mem[pose_idx_q[PIW-1:0]];
  assign dwell_done_s = (DWELL_FRAMES == 0) ||
                        (frame_tick_s && ((dwell_q + 1'b1) == DWC'(DWELL_FRAMES)));

  // Next-state: frame timer, slew, target writes, command priority and FSM.
  always_comb begin
    state_d      = state_q;
    pose_count_d = pose_count_q;
    pose_idx_d   = pose_idx_q;
    dwell_d      = dwell_q;
    mem_we_s     = 1'b0;
    fcnt_d       = frame_tick_s ? '0 : fcnt_q + 1'b1;
    for (int i = 0; i < 4; i++) begin
      tgt_d[i] = tgt_q[i];
      cmd_d[i] = frame_tick_s ? slew_step(cmd_q[i], tgt_q[i]) : cmd_q[i];
    end
    if (target_valid && (state_q == S_LIVE)) tgt_d[target_sel] = clamp_us(target_us);
    else tgt_d[target_sel] = tgt_q[target_sel];

    // Pulse priority is on the raw pulses: a higher one drops the rest.
    if (stop) begin
      if (state_q != S_LIVE) begin
        for (int i = 0; i < 4; i++) tgt_d[i] = cmd_q[i];
        state_d = S_LIVE;
      end else begin
        state_d = state_q;
      end
    end else if (home) begin
      for (int i = 0; i < 4; i++) tgt_d[i] = 12'(CENTER_US);
      pose_idx_d = 3'd0;
      state_d    = S_HOMING;
    end else begin
      case (state_q)
        S_LIVE: begin
          if (play) begin
            if (pose_count_q != 4'd0) begin
              pose_idx_d = 3'd0;
              state_d    = S_LOAD;
            end else begin
              state_d = S_LIVE;
            end
          end else if (store) begin
            if (!full_s) begin
              mem_we_s     = 1'b1;
              pose_count_d = pose_count_q + 4'd1;
            end else begin
              mem_we_s = 1'b0;
            end
          end else if (clear) begin
            pose_count_d = 4'd0;
          end else begin
            state_d = S_LIVE;
          end
        end
        S_HOMING: begin
          if (settled_s) state_d = S_LIVE;
          else state_d = S_HOMING;
        end
        S_LOAD: begin
          tgt_d[0] = pose_rd_s[11:0];
          tgt_d[1] = pose_rd_s[23:12];
          tgt_d[2] = pose_rd_s[35:24];
          tgt_d[3] = pose_rd_s[47:36];
          state_d  = S_MOVE;
        end
        S_MOVE: begin
          if (settled_s) begin
            dwell_d = '0;
            state_d = S_DWELL;
          end else begin
            state_d = S_MOVE;
          end
        end
        S_DWELL: begin
          if (dwell_done_s) begin
            if (pose_idx_q == 3'(pose_count_q - 4'd1)) begin
              pose_idx_d = 3'd0;
              state_d    = loop_en ? S_LOAD : S_LIVE;
              if (!loop_en) pose_idx_d = pose_idx_q;
              else pose_idx_d = 3'd0;
            end else begin
              pose_idx_d = pose_idx_q + 3'd1;
              state_d    = S_LOAD;
            end
          end else if (frame_tick_s) begin
            dwell_d = dwell_q + 1'b1;
          end else begin
            dwell_d = dwell_q;
          end
        end
        default: state_d = S_LIVE;
      endcase
    end
  end

  // State, counters, targets and commands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_LIVE;
      fcnt_q       <= '0;
      dwell_q      <= '0;
      pose_count_q <= 4'd0;
      pose_idx_q   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        tgt_q[i] <= 12'(CENTER_US);
        cmd_q[i] <= 12'(CENTER_US);
      end
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      dwell_q      <= dwell_d;
      pose_count_q <= pose_count_d;
      pose_idx_q   <= pose_idx_d;
      for (int i = 0; i < 4; i++) begin
        tgt_q[i] <= tgt_d[i];
        cmd_q[i] <= cmd_d[i];
      end
    end
  end

  // Pose memory survives reset; only pose_count is cleared.
  always_ff @(posedge CLK) begin
    if (mem_we_s) pose_mem[pose_count_q[PIW-1:0]] <= {tgt_q[3], tgt_q[2], tgt_q[1], tgt_q[0]};
  end

  assign cmd0         = cmd_q[0];
  assign cmd1         = cmd_q[1];
  assign cmd2         = cmd_q[2];
  assign cmd3         = cmd_q[3];
  assign state        = state_q;
  assign busy         = (state_q != S_LIVE);
  assign target_ready = (state_q == S_LIVE);
  assign settled      = settled_s;
  assign pose_idx     = pose_idx_q;
  assign pose_count   = pose_count_q;
  assign mem_full     = full_s;
  assign frame_tick   = frame_tick_s;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Directed bench for servo_motion_sequencer: table of target/slew vectors
// plus hand-written playback, stop/home and pose-memory sequences.
module tb_servo_motion_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        target_valid = 1'b0;
  logic        target_ready;
  logic [1:0]  target_sel = 2'd0;
  logic [11:0] target_us = 12'd0;
  logic        store = 1'b0, clear = 1'b0, play = 1'b0, loop_en = 1'b0;
  logic        stop = 1'b0, home = 1'b0;
  logic [11:0] cmd0, cmd1, cmd2, cmd3;
  logic [2:0]  state;
  logic        busy, settled, mem_full, frame_tick;
  logic [2:0]  pose_idx;
  logic [3:0]  pose_count;

  int tests = 0;
  int fails = 0;

  localparam int P_STORE = 0, P_CLEAR = 1, P_PLAY = 2, P_STOP = 3, P_HOME = 4;

  servo_motion_sequencer #(
    .CLK_FREQ_HZ(1_000_000), .FRAME_US(100), .DWELL_FRAMES(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .target_valid(target_valid), .target_ready(target_ready),
    .target_sel(target_sel), .target_us(target_us),
    .store(store), .clear(clear), .play(play), .loop_en(loop_en),
    .stop(stop), .home(home),
    .cmd0(cmd0), .cmd1(cmd1), .cmd2(cmd2), .cmd3(cmd3),
    .state(state), .busy(busy), .settled(settled),
    .pose_idx(pose_idx), .pose_count(pose_count),
    .mem_full(mem_full), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [11:0] us;
    int          ticks;
    logic [11:0] e0, e1, e2, e3;
    logic        es;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_for_tick();
    int guard;
    guard = 0;
    while (frame_tick !== 1'b1 && guard < 250) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 250) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got no frame_tick within 250 cycles");
    end
  endtask

  // Returns at the negedge just after the n-th frame update edge.
  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      wait_for_tick();
      @(negedge CLK);
    end
  endtask

  task automatic write_target(input logic [1:0] sel, input logic [11:0] us);
    if (frame_tick === 1'b1) @(negedge CLK);
    target_sel   = sel;
    target_us    = us;
    target_valid = 1'b1;
    @(negedge CLK);
    target_valid = 1'b0;
  endtask

  task automatic pulse(input int which);
    case (which)
      P_STORE: store = 1'b1;
      P_CLEAR: clear = 1'b1;
      P_PLAY:  play  = 1'b1;
      P_STOP:  stop  = 1'b1;
      default: home  = 1'b1;
    endcase
    @(negedge CLK);
    store = 1'b0; clear = 1'b0; play = 1'b0; stop = 1'b0; home = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{1'b1, 2'd2, 12'd1600, 1,  12'd1500, 12'd1500, 12'd1520, 12'd1500, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 12'd0,    1,  12'd1500, 12'd1500, 12'd1540, 12'd1500, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 12'd0,    1,  12'd1500, 12'd1500, 12'd1560, 12'd1500, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 12'd0,    1,  12'd1500, 12'd1500, 12'd1580, 12'd1500, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 12'd0,    1,  12'd1500, 12'd1500, 12'd1600, 12'd1500, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 12'd3000, 54, 12'd2580, 12'd1500, 12'd1600, 12'd1500, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 12'd0,    1,  12'd2600, 12'd1500, 12'd1600, 12'd1500, 1'b1};
    vecs[7] = '{1'b1, 2'd0, 12'd100,  97, 12'd660,  12'd1500, 12'd1600, 12'd1500, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 12'd0,    1,  12'd650,  12'd1500, 12'd1600, 12'd1500, 1'b1};
    vecs[9] = '{1'b1, 2'd1, 12'd1510, 1,  12'd650,  12'd1510, 12'd1600, 12'd1500, 1'b1};

    // Reset values and frame strobe period
    repeat (3) @(negedge CLK);
    chk("rst_cmd0", cmd0, 1500);
    chk("rst_cmd3", cmd3, 1500);
    chk("rst_state", state, 0);
    chk("rst_ready", target_ready, 1);
    chk("rst_settled", settled, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", mem_full, 0);
    chk("rst_count", pose_count, 0);
    chk("rst_tick", frame_tick, 0);
    RST_N = 1'b1;
    cyc = 0;
    while (frame_tick !== 1'b1 && cyc < 250) begin @(negedge CLK); cyc++; end
    chk("first_tick_cycles", cyc, 99);
    @(negedge CLK);
    cyc = 1;
    while (frame_tick !== 1'b1 && cyc < 250) begin @(negedge CLK); cyc++; end
    chk("tick_period", cyc, 100);

    // Slew, clamp and odd-step vectors
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].wr) write_target(vecs[v].sel, vecs[v].us);
      tick_wait(vecs[v].ticks);
      chk($sformatf("vec%0d_cmd0", v), cmd0, vecs[v].e0);
      chk($sformatf("vec%0d_cmd1", v), cmd1, vecs[v].e1);
      chk($sformatf("vec%0d_cmd2", v), cmd2, vecs[v].e2);
      chk($sformatf("vec%0d_cmd3", v), cmd3, vecs[v].e3);
      chk($sformatf("vec%0d_settled", v), settled, vecs[v].es);
    end

    // Home from far away: 650 -> 1500 takes 43 frames
    pulse(P_HOME);
    chk("home_state", state, 1);
    chk("home_ready", target_ready, 0);
    chk("home_busy", busy, 1);
    tick_wait(42);
    chk("home_cmd0_42", cmd0, 1490);
    chk("home_settled_42", settled, 0);
    tick_wait(1);
    chk("home_cmd0_43", cmd0, 1500);
    chk("home_cmd2", cmd2, 1500);
    chk("home_still_homing", state, 1);
    @(negedge CLK);
    chk("home_to_live", state, 0);

    // Record pose A (all 1500) and pose B (cmd0 1560, stored with a same-cycle write)
    pulse(P_STORE);
    chk("store_a_count", pose_count, 1);
    write_target(2'd0, 12'd1560);
    store = 1'b1; target_valid = 1'b1; target_sel = 2'd0; target_us = 12'd1500;
    @(negedge CLK);
    store = 1'b0; target_valid = 1'b0;
    chk("store_b_count", pose_count, 2);
    chk("store_b_write_settled", settled, 1);

    // Playback without looping
    pulse(P_PLAY);
    chk("play_load", state, 2);
    chk("play_busy", busy, 1);
    @(negedge CLK);
    chk("play_move_a", state, 3);
    tick_wait(2);
    chk("dwell_a_exit", state, 2);
    chk("dwell_a_idx", pose_idx, 1);
    @(negedge CLK);
    chk("play_move_b", state, 3);
    tick_wait(1);
    chk("ramp_b1", cmd0, 1520);
    tick_wait(1);
    chk("ramp_b2", cmd0, 1540);
    tick_wait(1);
    chk("ramp_b3", cmd0, 1560);
    chk("ramp_b3_state", state, 3);
    @(negedge CLK);
    chk("dwell_b", state, 4);
    chk("dwell_b_cmd1", cmd1, 1500);
    tick_wait(2);
    chk("play_end_state", state, 0);
    chk("play_end_idx", pose_idx, 1);
    chk("play_end_cmd0", cmd0, 1560);

    // Looping playback: A, B, A ...
    loop_en = 1'b1;
    pulse(P_PLAY);
    chk("loop_load", state, 2);
    tick_wait(3);
    chk("loop_a_cmd0", cmd0, 1500);
    tick_wait(2);
    chk("loop_a_exit_idx", pose_idx, 1);
    tick_wait(3);
    chk("loop_b_cmd0", cmd0, 1560);
    tick_wait(2);
    chk("loop_wrap_state", state, 2);
    chk("loop_wrap_idx", pose_idx, 0);
    @(negedge CLK);
    tick_wait(2);
    chk("loop_again_cmd0", cmd0, 1520);

    // Stop mid-ramp freezes in place
    pulse(P_STOP);
    loop_en = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_settled", settled, 1);
    tick_wait(1);
    chk("stop_hold_cmd0", cmd0, 1520);

    // Stop in the same cycle as frame_tick during homing
    write_target(2'd3, 12'd1600);
    tick_wait(5);
    chk("cmd3_1600", cmd3, 1600);
    pulse(P_HOME);
    tick_wait(2);
    chk("home2_cmd0", cmd0, 1500);
    chk("home2_cmd3", cmd3, 1560);
    wait_for_tick();
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("stoptick_state", state, 0);
    chk("stoptick_cmd3", cmd3, 1540);
    chk("stoptick_settled", settled, 0);
    tick_wait(1);
    chk("stoptick_back", cmd3, 1560);
    chk("stoptick_settled2", settled, 1);
    pulse(P_HOME);
    tick_wait(3);
    chk("home3_cmd3", cmd3, 1500);
    @(negedge CLK);
    chk("home3_live", state, 0);

    // Memory limits and play/store collisions
    pulse(P_CLEAR);
    chk("clear_count", pose_count, 0);
    pulse(P_PLAY);
    chk("play_empty_ignored", state, 0);
    pulse(P_STORE);
    chk("store_one", pose_count, 1);
    store = 1'b1; play = 1'b1;
    @(negedge CLK);
    store = 1'b0; play = 1'b0;
    chk("play_wins_state", state, 2);
    chk("play_wins_count", pose_count, 1);
    pulse(P_STOP);
    chk("stop_from_load", state, 0);
    pulse(P_CLEAR);
    for (int s = 0; s < 9; s++) pulse(P_STORE);
    chk("nine_stores_count", pose_count, 8);
    chk("nine_stores_full", mem_full, 1);

    // Asynchronous reset during playback
    pulse(P_PLAY);
    tick_wait(1);
    chk("pre_reset_busy", busy, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_count", pose_count, 0);
    chk("async_rst_idx", pose_idx, 0);
    chk("async_rst_full", mem_full, 0);
    chk("async_rst_cmd0", cmd0, 1500);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", target_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
